// File: rtl/rtc_rgs_mc.sv
// rtl/rtc_rgs_mc.sv - RTC register block with coherent time reads and PPS timestamp channels
// Optional: RTC_RGS_IRQ_EN adds IRQ_MASK storage and the irq_o output.
module rtc_rgs_mc #(
   parameter logic [23:0] BLK_ADDR     = 24'h000010,
   parameter int          NUM_PTS      = 2,
   parameter int          PULSE_W      = 1,
   parameter logic [31:0] TICK_INC_RST = 32'h1999_9999
) (
   input  logic                    bus2ip_clk,
   input  logic                    bus2ip_rst,
   input  logic [31:0]             bus2ip_addr_i,
   input  logic [31:0]             bus2ip_data_i,
   input  logic                    bus2ip_rd_ce_i,
   input  logic                    bus2ip_wr_ce_i,
   output logic [31:0]             ip2bus_data_o,
   input  logic [79:0]             rtc_std_i,
   input  logic [15:0]             rtc_fns_i,
   input  logic [NUM_PTS-1:0]      pts_stb_i,
   input  logic [80*NUM_PTS-1:0]   pts_std_i,
   input  logic [16*NUM_PTS-1:0]   pts_fns_i,
   output logic [31:0]             tick_inc_o,
   output logic [31:0]             ns_offset_o,
   output logic [47:0]             sc_offset_o,
   output logic                    offset_valid_o,
   output logic                    clear_rtc_o,
   output logic [31:0]             pps_width_o,
   output logic                    intxms_sel_o
`ifdef RTC_RGS_IRQ_EN
   ,
   output logic                    irq_o
`endif
);

   localparam logic [7:0] OFF_CTL   = 8'h00;
   localparam logic [7:0] OFF_TICK  = 8'h04;
   localparam logic [7:0] OFF_NS    = 8'h08;
   localparam logic [7:0] OFF_SC_HI = 8'h0C;
   localparam logic [7:0] OFF_SC_LO = 8'h10;
   localparam logic [7:0] OFF_TM0   = 8'h14;
   localparam logic [7:0] OFF_TM1   = 8'h18;
   localparam logic [7:0] OFF_TM2   = 8'h1C;
   localparam logic [7:0] OFF_PPSW  = 8'h20;
   localparam logic [7:0] OFF_STAT  = 8'h24;
`ifdef RTC_RGS_IRQ_EN
   localparam logic [7:0] OFF_IRQ   = 8'h28;
`endif
   localparam logic [3:0] PW        = 4'(PULSE_W);

   function automatic logic [7:0] pts_off(input int c, input int w);
      return 8'(64 + 16 * c + w);
   endfunction

   logic                blk_sel, rd_en, wr_en;
   logic [7:0]          off;
   logic [3:0]          ov_cnt, cl_cnt;
   logic [47:0]         snap_std;
   logic [15:0]         snap_fns;
   logic [79:0]         pts_std_q [NUM_PTS];
   logic [15:0]         pts_fns_q [NUM_PTS];
   logic [NUM_PTS-1:0]  pts_vld, pts_ovf, vld_clr, ovf_clr;
   logic [31:0]         rd_mux;
`ifdef RTC_RGS_IRQ_EN
   logic [NUM_PTS-1:0]  irq_msk_pts;
   logic                irq_msk_ovf;
`endif

   assign blk_sel        = (bus2ip_addr_i[31:8] == BLK_ADDR);
   assign rd_en          = bus2ip_rd_ce_i & blk_sel;
   assign wr_en          = bus2ip_wr_ce_i & blk_sel;
   assign off            = bus2ip_addr_i[7:0];
   assign offset_valid_o = (ov_cnt != 4'd0);
   assign clear_rtc_o    = (cl_cnt != 4'd0);

   // Valid is cleared by a PTS2 read or W1C; overflow only by W1C.
   always_comb begin
      vld_clr = '0;
      ovf_clr = '0;
      for (int c = 0; c < NUM_PTS; c++) begin
         vld_clr[c] = (rd_en && off == pts_off(c, 8)) ||
                      (wr_en && off == OFF_STAT && bus2ip_data_i[c]);
         ovf_clr[c] = wr_en && off == OFF_STAT && bus2ip_data_i[8+c];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_CTL:   rd_mux = {29'h0, intxms_sel_o, clear_rtc_o, offset_valid_o};
         OFF_TICK:  rd_mux = tick_inc_o;
         OFF_NS:    rd_mux = ns_offset_o;
         OFF_SC_HI: rd_mux = {16'h0, sc_offset_o[47:32]};
         OFF_SC_LO: rd_mux = sc_offset_o[31:0];
         OFF_TM0:   rd_mux = rtc_std_i[79:48];
         OFF_TM1:   rd_mux = snap_std[47:16];
         OFF_TM2:   rd_mux = {snap_std[15:0], snap_fns};
         OFF_PPSW:  rd_mux = pps_width_o;
         OFF_STAT: begin
            rd_mux[NUM_PTS-1:0]  = pts_vld;
            rd_mux[8 +: NUM_PTS] = pts_ovf;
         end
`ifdef RTC_RGS_IRQ_EN
         OFF_IRQ: begin
            rd_mux[NUM_PTS-1:0] = irq_msk_pts;
            rd_mux[8]           = irq_msk_ovf;
         end
`endif
         default: ;
      endcase
      for (int c = 0; c < NUM_PTS; c++) begin
         if (off == pts_off(c, 0)) rd_mux = pts_std_q[c][79:48];
         if (off == pts_off(c, 4)) rd_mux = pts_std_q[c][47:16];
         if (off == pts_off(c, 8)) rd_mux = {pts_std_q[c][15:0], pts_fns_q[c]};
      end
   end

   always_ff @(posedge bus2ip_clk) begin
      if (bus2ip_rst) begin
         ip2bus_data_o <= '0;
         tick_inc_o    <= TICK_INC_RST;
         ns_offset_o   <= '0;
         sc_offset_o   <= '0;
         pps_width_o   <= '0;
         intxms_sel_o  <= 1'b0;
         ov_cnt        <= '0;
         cl_cnt        <= '0;
         snap_std      <= '0;
         snap_fns      <= '0;
         pts_vld       <= '0;
         pts_ovf       <= '0;
         for (int c = 0; c < NUM_PTS; c++) begin
            pts_std_q[c] <= '0;
            pts_fns_q[c] <= '0;
         end
`ifdef RTC_RGS_IRQ_EN
         irq_msk_pts   <= '0;
         irq_msk_ovf   <= 1'b0;
         irq_o         <= 1'b0;
`endif
      end else begin
         ip2bus_data_o <= rd_en ? rd_mux : '0;
         if (rd_en && off == OFF_TM0) begin
            snap_std <= rtc_std_i[47:0];
            snap_fns <= rtc_fns_i;
         end
         // An active pulse ignores new triggers until it has run out.
         if (ov_cnt != 4'd0)
            ov_cnt <= ov_cnt - 4'd1;
         else if (wr_en && off == OFF_CTL && bus2ip_data_i[0])
            ov_cnt <= PW;
         if (cl_cnt != 4'd0)
            cl_cnt <= cl_cnt - 4'd1;
         else if (wr_en && off == OFF_CTL && bus2ip_data_i[1])
            cl_cnt <= PW;
         if (wr_en) begin
            case (off)
               OFF_CTL:   intxms_sel_o <= bus2ip_data_i[2];
               OFF_TICK:  tick_inc_o <= bus2ip_data_i;
               OFF_NS:    ns_offset_o <= bus2ip_data_i;
               OFF_SC_HI: sc_offset_o[47:32] <= bus2ip_data_i[15:0];
               OFF_SC_LO: sc_offset_o[31:0] <= bus2ip_data_i;
               OFF_PPSW:  pps_width_o <= bus2ip_data_i;
`ifdef RTC_RGS_IRQ_EN
               OFF_IRQ: begin
                  irq_msk_pts <= bus2ip_data_i[NUM_PTS-1:0];
                  irq_msk_ovf <= bus2ip_data_i[8];
               end
`endif
               default: ;
            endcase
         end
         // A strobe beats a coincident clear; a new overflow beats its W1C.
         for (int c = 0; c < NUM_PTS; c++) begin
            if (ovf_clr[c]) pts_ovf[c] <= 1'b0;
            if (pts_stb_i[c]) begin
               if (!pts_vld[c] || vld_clr[c]) begin
                  pts_std_q[c] <= pts_std_i[80*c +: 80];
                  pts_fns_q[c] <= pts_fns_i[16*c +: 16];
                  pts_vld[c]   <= 1'b1;
               end else begin
                  pts_ovf[c]   <= 1'b1;
               end
            end else if (vld_clr[c]) begin
               pts_vld[c] <= 1'b0;
            end
         end
`ifdef RTC_RGS_IRQ_EN
         irq_o <= |(pts_vld & irq_msk_pts) | (irq_msk_ovf & |pts_ovf);
`endif
      end
   end

endmodule

// File: tb/tb_rtc_rgs_mc.sv
// tb/tb_rtc_rgs_mc.sv - scoreboard bench for rtc_rgs_mc against a register-map model
module tb_rtc_rgs_mc;
   localparam int          NP  = 2;
   localparam int          PW  = 3;
   localparam logic [23:0] BLK = 24'h000010;
   localparam logic [31:0] B   = {BLK, 8'h00};

   logic                 clk = 1'b0;
   logic                 rst, rd, wr;
   logic [31:0]          addr, wdata, rdata;
   logic [79:0]          std;
   logic [15:0]          fns;
   logic [NP-1:0]        stb;
   logic [80*NP-1:0]     pstd;
   logic [16*NP-1:0]     pfns;
   logic [31:0]          tick_inc, ns_ofst, pps_w;
   logic [47:0]          sc_ofst;
   logic                 ofs_vld, clr_rtc, ixs;
`ifdef RTC_RGS_IRQ_EN
   logic                 irq;
`endif

   always #5 clk = ~clk;

   rtc_rgs_mc #(.BLK_ADDR(BLK), .NUM_PTS(NP), .PULSE_W(PW), .TICK_INC_RST(32'h1999_9999)) dut (
      .bus2ip_clk(clk), .bus2ip_rst(rst), .bus2ip_addr_i(addr), .bus2ip_data_i(wdata),
      .bus2ip_rd_ce_i(rd), .bus2ip_wr_ce_i(wr), .ip2bus_data_o(rdata),
      .rtc_std_i(std), .rtc_fns_i(fns), .pts_stb_i(stb), .pts_std_i(pstd), .pts_fns_i(pfns),
      .tick_inc_o(tick_inc), .ns_offset_o(ns_ofst), .sc_offset_o(sc_ofst),
      .offset_valid_o(ofs_vld), .clear_rtc_o(clr_rtc), .pps_width_o(pps_w), .intxms_sel_o(ixs)
`ifdef RTC_RGS_IRQ_EN
      , .irq_o(irq)
`endif
   );

   // reference model state
   logic [31:0] m_tick, m_ns, m_ppsw;
   logic [47:0] m_sc, m_snap;
   logic [15:0] m_snapf;
   logic        m_ixs, m_mskovf, m_irq;
   logic [79:0] m_pstd [NP];
   logic [15:0] m_pfns [NP];
   logic [NP-1:0] m_val, m_ovf, m_msk;
   int          off_rem, clr_rem;

   logic [31:0] exp_q [$];
   int          n_chk = 0, n_fail = 0;
   logic        chk_en = 1'b0, rd_d = 1'b0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_tick = 32'h1999_9999; m_ns = 0; m_ppsw = 0; m_sc = 0; m_snap = 0; m_snapf = 0;
      m_ixs = 0; m_mskovf = 0; m_irq = 0; m_val = 0; m_ovf = 0; m_msk = 0;
      off_rem = 0; clr_rem = 0;
      for (int c = 0; c < NP; c++) begin m_pstd[c] = 0; m_pfns[c] = 0; end
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      int o, ch;
      logic [31:0] v;
      o = int'(a[7:0]);
      v = 0;
      if (a[31:8] != BLK) return 0;
      case (o)
         'h00: v = {29'h0, m_ixs, clr_rem > 0, off_rem > 0};
         'h04: v = m_tick;
         'h08: v = m_ns;
         'h0C: v = {16'h0, m_sc[47:32]};
         'h10: v = m_sc[31:0];
         'h14: v = std[79:48];
         'h18: v = m_snap[47:16];
         'h1C: v = {m_snap[15:0], m_snapf};
         'h20: v = m_ppsw;
         'h24: v = (32'(m_ovf) << 8) | 32'(m_val);
`ifdef RTC_RGS_IRQ_EN
         'h28: v = (32'(m_mskovf) << 8) | 32'(m_msk);
`endif
         default: v = 0;
      endcase
      if (o >= 64 && o < 64 + 16 * NP) begin
         ch = (o - 64) / 16;
         case (o % 16)
            0: v = m_pstd[ch][79:48];
            4: v = m_pstd[ch][47:16];
            8: v = {m_pstd[ch][15:0], m_pfns[ch]};
            default: v = 0;
         endcase
      end
      return v;
   endfunction

   // applies the effect of one clock edge given the inputs that were presented to it
   task automatic model_update(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [NP-1:0] s);
      logic hit, vc, oc, nirq;
      int o;
      hit = (a[31:8] == BLK);
      o = int'(a[7:0]);
      nirq = |(m_val & m_msk) | (m_mskovf & |m_ovf);
      if (r && hit && o == 'h14) begin m_snap = std[47:0]; m_snapf = fns; end
      if (off_rem > 0) off_rem--; else if (w && hit && o == 0 && d[0]) off_rem = PW;
      if (clr_rem > 0) clr_rem--; else if (w && hit && o == 0 && d[1]) clr_rem = PW;
      if (w && hit) begin
         case (o)
            'h00: m_ixs = d[2];
            'h04: m_tick = d;
            'h08: m_ns = d;
            'h0C: m_sc[47:32] = d[15:0];
            'h10: m_sc[31:0] = d;
            'h20: m_ppsw = d;
`ifdef RTC_RGS_IRQ_EN
            'h28: begin m_msk = d[NP-1:0]; m_mskovf = d[8]; end
`endif
            default: ;
         endcase
      end
      for (int c = 0; c < NP; c++) begin
         vc = (r && hit && o == 'h48 + 16 * c) || (w && hit && o == 'h24 && d[c]);
         oc = w && hit && o == 'h24 && d[8+c];
         if (oc) m_ovf[c] = 0;
         if (s[c]) begin
            if (!m_val[c] || vc) begin
               m_pstd[c] = pstd[80*c +: 80]; m_pfns[c] = pfns[16*c +: 16]; m_val[c] = 1;
            end else m_ovf[c] = 1;
         end else if (vc) m_val[c] = 0;
      end
      m_irq = nirq;
   endtask

   task automatic step(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [NP-1:0] s);
      rd = r; wr = w; addr = a; wdata = d; stb = s;
      if (r) exp_q.push_back(ref_read(a));
      @(posedge clk); #1;
      model_update(r, w, a, d, s);
      rd = 0; wr = 0; stb = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
   endtask

   // monitor: read data presented one clock after each captured read, plus register outputs
   always @(posedge clk) rd_d <= rd;
   always @(negedge clk) begin
      if (chk_en) begin
         if (rd_d) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rdata", rdata, exp_q.pop_front());
         end else chk("rdata_idle", rdata, 0);
         chk("tick_inc", tick_inc, m_tick);
         chk("ns_offset", ns_ofst, m_ns);
         chk("sc_offset", sc_ofst, m_sc);
         chk("pps_width", pps_w, m_ppsw);
         chk("intxms_sel", ixs, m_ixs);
         chk("offset_valid", ofs_vld, off_rem > 0);
         chk("clear_rtc", clr_rtc, clr_rem > 0);
`ifdef RTC_RGS_IRQ_EN
         chk("irq", irq, m_irq);
`endif
      end
   end

   logic [7:0] offs [23] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24,
                             8'h28, 8'h2C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58,
                             8'h60, 8'h68, 8'h70, 8'h78};

   initial begin
      rst = 1; rd = 0; wr = 0; addr = 0; wdata = 0; stb = 0;
      std = 0; fns = 0; pstd = 0; pfns = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      chk_en = 1;

      // reset values
      step(1, 0, B | 32'h04, 0, 0);
      step(1, 0, B | 32'h00, 0, 0);
      step(1, 0, B | 32'h24, 0, 0);

      // pulses, with a rewrite during the pulse, then intxms select
      step(0, 1, B | 32'h00, 32'h3, 0);
      step(1, 0, B | 32'h00, 0, 0);
      step(0, 1, B | 32'h00, 32'h3, 0);
      idle(3);
      step(0, 1, B | 32'h00, 32'h4, 0);
      step(1, 0, B | 32'h00, 0, 0);

      // coherent snapshot
      std = 80'h0000_0000_0005_1234_5678; fns = 16'hBEEF;
      step(1, 0, B | 32'h14, 0, 0);
      std = {$urandom, $urandom, $urandom}; fns = 16'($urandom);
      step(1, 0, B | 32'h18, 0, 0);
      step(1, 0, B | 32'h1C, 0, 0);

      // channel 1 overflow, retention and W1C
      pstd[80 +: 80] = 80'h0000_0000_0111_2222_3333; pfns[16 +: 16] = 16'h4444;
      step(0, 0, 0, 0, 2'b10);
      pstd[80 +: 80] = 80'hFFFF_EEEE_DDDD_CCCC_BBBB; pfns[16 +: 16] = 16'hAAAA;
      step(0, 0, 0, 0, 2'b10);
      step(1, 0, B | 32'h24, 0, 0);
      step(1, 0, B | 32'h50, 0, 0);
      step(1, 0, B | 32'h54, 0, 0);
      step(0, 1, B | 32'h24, 32'h202, 0);
      step(1, 0, B | 32'h24, 0, 0);

      // seconds offset and block address mismatch
      step(0, 1, B | 32'h0C, 32'hABCD, 0);
      step(0, 1, B | 32'h10, 32'h1122_3344, 0);
      step(0, 1, 32'h0000_110C, 32'h5555, 0);
      step(0, 1, 32'h0000_2010, 32'h6666_7777, 0);
      step(1, 0, 32'h0000_1104, 0, 0);

      // strobe coincident with PTS2 read on channel 0
      pstd[0 +: 80] = 80'h1234_5678_9ABC_DEF0_1357; pfns[0 +: 16] = 16'h2468;
      step(0, 0, 0, 0, 2'b01);
      pstd[0 +: 80] = 80'h0BAD_F00D_0BAD_F00D_0BAD; pfns[0 +: 16] = 16'hCAFE;
      step(1, 0, B | 32'h48, 0, 2'b01);
      step(1, 0, B | 32'h24, 0, 0);
      step(1, 0, B | 32'h48, 0, 0);

      // simultaneous read and write
      step(1, 1, B | 32'h08, 32'hDEAD_BEEF, 0);
      step(1, 0, B | 32'h08, 0, 0);

      // reset in the middle of a pulse
      step(0, 1, B | 32'h00, 32'h1, 0);
      idle(1);
      do_reset();
      idle(2);

      // interrupt from channel 0 valid
      step(0, 1, B | 32'h28, 32'h1, 0);
      step(0, 0, 0, 0, 2'b01);
      idle(2);
      step(1, 0, B | 32'h48, 0, 0);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         a = {($urandom_range(0, 7) == 0) ? 24'($urandom_range(0, 31)) : BLK,
              offs[$urandom_range(0, 22)]};
         std = {$urandom, $urandom, $urandom}; fns = 16'($urandom);
         for (int c = 0; c < NP; c++) begin
            pstd[80*c +: 80] = {$urandom, $urandom, $urandom};
            pfns[16*c +: 16] = 16'($urandom);
         end
         if ($urandom_range(0, 149) == 0) do_reset();
         else step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a, $urandom,
                   NP'($urandom_range(0, 3) == 0 ? $urandom : 0));
      end
      idle(2);
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
